iobus_sseg_ctrl: RTL and testbench
==================================

// Module: iobus_sseg_ctrl
// PURPOSE
//  IOBUS responder that owns the Basys3 4-digit seven-segment display. The MCU writes a
//  16-bit hex value and control bits over IOBUS. The block autonomously scans the digits,
//  so firmware no longer bit-bangs cathodes and anodes. Sits beside the board wrapper's
//  LED/switch ports; its read data is ORed into the IOBUS input mux when SEL is high.
// PARAMETERS
//  DATA_ADDR    32'h1100C010  R/W: [15:0] hex value, nibble k drives digit k (digit 0 = rightmost)
//  CTRL_ADDR    32'h1100C014  R/W: [0] EN, [1] BLANK (leading-zero blank), [7:4] DP mask
//  STATUS_ADDR  32'h1100C018  RO:  [1:0] current digit index; writes ignored
//  REFRESH_CNT  50000         clk cycles per digit (>=2)
// PORTS
//  clk         in   1   system clock (divided MCU clock)
//  RST_N       in   1   synchronous, active-low reset
//  IOBUS_ADDR  in   32  bus address from MCU
//  IOBUS_OUT   in   32  write data from MCU
//  IOBUS_WR    in   1   write strobe, sampled on clk rising edge
//  RD_DATA     out  32  read data for current IOBUS_ADDR (combinational); 0 when SEL=0
//  SEL         out  1   IOBUS_ADDR matches one of the three addresses (combinational)
//  segs        out  8   cathodes, active-low: [0]=a .. [6]=g, [7]=dp
//  an          out  4   anodes, active-low one-hot: an[k] enables digit k
// BEHAVIOUR
//  - Reset (RST_N=0 at a clk edge): data=16'h0, EN=1, BLANK=1, DP=4'h0, refresh cnt=0,
//    digit=0, segs=8'hFF, an=4'hF. Reset overrides a same-cycle write.
//  - Write: IOBUS_WR=1 and ADDR==DATA_ADDR -> data<=IOBUS_OUT[15:0].
//    ADDR==CTRL_ADDR -> ctrl<={IOBUS_OUT[7:4],IOBUS_OUT[1:0]}.
//    All other addresses and other bits are ignored.
//  - Read: RD_DATA zero-extends the register (CTRL reads {24'b0,DP,2'b0,BLANK,EN}).
//    STATUS reads the digit index. Reads have no side effects.
//  - Scan counter: when EN=1, cnt increments each cycle. At cnt==REFRESH_CNT-1, cnt<=0 and
//    digit<=digit+1 (wraps 3->0). When EN=0, cnt and digit are held at 0.
//  - Outputs registered: an/segs at edge t+1 reflect digit, data and ctrl as they stood
//    after edge t. A write is therefore visible on segs one cycle after the write edge,
//    with no wait for the next refresh. This also holds when the write coincides with a
//    digit advance.
//  - EN=0: an=4'hF, segs=8'hFF (display dark) from the next cycle.
//  - EN=1: an=~(4'b1<<digit). segs[6:0]=~hexfont(data nibble[digit]). segs[7]=~DP[digit].
//  - BLANK=1: digit k in 1..3 is blanked (segs[6:0]=7'h7F) iff nibbles k..3 are all 0.
//    Digit 0 is never blanked. The DP bit is unaffected by blanking.
//  - hexfont: standard 0-9, A, b, C, d, E, F glyphs. For example, 0->a..f on, 8->all on,
//    b->c,d,e,f,g.
//  - Mid-scan reset returns to digit 0 with cnt=0 and dark outputs for one cycle. Each
//    digit is lit for exactly REFRESH_CNT cycles, including digit 0 after reset.
// STRUCTURE
//  - otter_io_pkg: the three address localparams; typedef seg_t (logic [7:0]); typedef
//    ctrl_t packed struct {dp[3:0], blank, en}; the hexfont function constant table.
//  - Sub-module sseg_hex_decoder: combinational 4-bit nibble -> 7-bit active-high
//    a..g, instantiated once on the selected nibble.
//  - Top: address decode, register file, refresh counter/digit FSM (4 states D0-D3,
//    advance on terminal count), blank logic, output register.
// TESTING (REFRESH_CNT=4)
//  1. Reset, no writes -> cycle 1: an=4'hE, segs=8'hC0 (digit0 '0'). Digits 1-3 blanked:
//     segs=8'hFF while an=D/B/7. Each an value lasts 4 cycles.
//  2. Write DATA=32'h0000_12AF -> digit0 segs=8'h8E ('F'), digit1 8'h88 ('A'),
//     digit2 8'hA4 ('2'), digit3 8'hF9 ('1').
//  3. Write DATA=32'h0000_0050, CTRL=32'h0000_0021 (EN=1, BLANK=0, DP[1]) ->
//     digit3/2=8'hC0, digit1=8'h12 ('5'+dp), digit0=8'hC0.
//  4. Write CTRL=0 mid-scan -> next cycle an=4'hF, segs=8'hFF; STATUS reads 0.
//     Re-enable -> digit0 lit for 4 cycles.
//  5. Read DATA/CTRL/STATUS/0x1100C000 -> SEL=1/1/1/0; RD_DATA = written values / 0.
//     Write STATUS=32'hFFFF_FFFF -> no state change.
//  6. Assert RST_N=0 with simultaneous DATA write at digit 2 -> data=0,
//     an=4'hF/segs=8'hFF next cycle, then digit0 scan restarts.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared definitions for the IOBUS seven-segment responder.
//  - IOBUS register addresses (data, control, status)
//  - seg_t:  cathode vector, active-low, [0]=a .. [6]=g, [7]=dp
//  - ctrl_t: control register fields {dp mask, leading-zero blank, enable}
//  - hexfont: nibble -> active-high a..g glyph lookup
package otter_io_pkg;

    localparam logic [31:0] DATA_ADDR   = 32'h1100C010;
    localparam logic [31:0] CTRL_ADDR   = 32'h1100C014;
    localparam logic [31:0] STATUS_ADDR = 32'h1100C018;

    typedef logic [7:0] seg_t;

    typedef struct packed {
        logic [3:0] dp;
        logic       blank;
        logic       en;
    } ctrl_t;

    // Bit order g..a (bit 6 = g, bit 0 = a), segment on = 1.
    localparam logic [6:0] HEXFONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    function automatic logic [6:0] hexfont(input logic [3:0] nibble);
        return HEXFONT[nibble];
    endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph decoder.
// Ports:
//  nibble_i  in  4  hex digit value
//  seg_o     out 7  active-high segments, [0]=a .. [6]=g
module sseg_hex_decoder
    import otter_io_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hexfont(nibble_i);

endmodule

// File: rtl/iobus_sseg_ctrl.sv
// IOBUS responder driving the Basys3 4-digit seven-segment display.
// Firmware writes a 16-bit hex value and control bits; the block scans
// the digits on its own, one digit every REFRESH_CNT clocks.
// Ports:
//  clk         in   1   system clock
//  RST_N       in   1   synchronous active-low reset
//  IOBUS_ADDR  in   32  bus address
//  IOBUS_OUT   in   32  write data
//  IOBUS_WR    in   1   write strobe
//  RD_DATA     out  32  combinational read data, 0 when not selected
//  SEL         out  1   address hits one of the three registers
//  segs        out  8   active-low cathodes, [7]=dp
//  an          out  4   active-low one-hot anodes
module iobus_sseg_ctrl
    import otter_io_pkg::*;
#(
    parameter int unsigned REFRESH_CNT = 50000
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        SEL,
    output seg_t        segs,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

    typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} digit_e;

    logic [15:0]      data_q, data_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_e           state_q, state_d;
    seg_t             segs_q, segs_d;
    logic [3:0]       an_q, an_d;

    logic             hit_data, hit_ctrl, hit_status;
    logic             tc;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             blank_digit;
    logic             unused_wdata;

    assign unused_wdata = ^IOBUS_OUT[31:16];

    // Address decode and read mux
    assign hit_data   = (IOBUS_ADDR == DATA_ADDR);
    assign hit_ctrl   = (IOBUS_ADDR == CTRL_ADDR);
    assign hit_status = (IOBUS_ADDR == STATUS_ADDR);
    assign SEL        = hit_data | hit_ctrl | hit_status;

    always_comb begin
        RD_DATA = 32'h0;
        if (hit_data)   RD_DATA = {16'h0, data_q};
        if (hit_ctrl)   RD_DATA = {24'h0, ctrl_q.dp, 2'b00, ctrl_q.blank, ctrl_q.en};
        if (hit_status) RD_DATA = {30'h0, state_q};
    end

    // Register file writes
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (IOBUS_WR && hit_data) data_d = IOBUS_OUT[15:0];
        if (IOBUS_WR && hit_ctrl) ctrl_d = '{dp: IOBUS_OUT[7:4], blank: IOBUS_OUT[1], en: IOBUS_OUT[0]};
    end

    // Refresh counter; tc marks the last cycle of the current digit
    always_comb begin
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (!ctrl_q.en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tc    = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Digit FSM: parked on D0 while disabled, advances on terminal count
    always_comb begin
        state_d = state_q;
        if (!ctrl_q.en) begin
            state_d = D0;
        end else if (tc) begin
            unique case (state_q)
                D0: state_d = D1;
                D1: state_d = D2;
                D2: state_d = D3;
                D3: state_d = D0;
            endcase
        end
    end

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
    always_comb begin
        unique case (state_q)
            D0: blank_digit = 1'b0;
            D1: blank_digit = (data_q[15:4]  == 12'h0);
            D2: blank_digit = (data_q[15:8]  == 8'h0);
            D3: blank_digit = (data_q[15:12] == 4'h0);
        endcase
    end

    assign nibble = data_q[{state_q, 2'b00} +: 4];

    sseg_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Output register input: built from the current (post-edge) state so a
    // register write shows on the very next edge.
    always_comb begin
        an_d   = 4'hF;
        segs_d = 8'hFF;
        if (ctrl_q.en) begin
            an_d      = ~(4'b0001 << state_q);
            segs_d[7] = ~ctrl_q.dp[state_q];
            segs_d[6:0] = (ctrl_q.blank && blank_digit) ? 7'h7F : ~glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            data_q  <= 16'h0;
            ctrl_q  <= '{dp: 4'h0, blank: 1'b1, en: 1'b1};
            cnt_q   <= '0;
            state_q <= D0;
            segs_q  <= 8'hFF;
            an_q    <= 4'hF;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            segs_q  <= segs_d;
            an_q    <= an_d;
        end
    end

    assign segs = segs_q;
    assign an   = an_q;

endmodule

// File: tb/tb_iobus_sseg_ctrl.sv
// Testbench for iobus_sseg_ctrl with a four-cycle refresh period.
module tb_iobus_sseg_ctrl;

    localparam int R = 4;
    localparam logic [31:0] A_DATA   = 32'h1100C010;
    localparam logic [31:0] A_CTRL   = 32'h1100C014;
    localparam logic [31:0] A_STATUS = 32'h1100C018;
    localparam logic [31:0] A_OTHER  = 32'h1100C000;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        SEL;
    logic [7:0]  segs;
    logic [3:0]  an;

    always #5 clk = ~clk;

    iobus_sseg_ctrl #(.REFRESH_CNT(R)) dut (
        .clk        (clk),
        .RST_N      (RST_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .RD_DATA    (RD_DATA),
        .SEL        (SEL),
        .segs       (segs),
        .an         (an)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: display contents plus "cycles since scan start".
    logic [15:0] m_data;
    logic        m_en, m_blank;
    logic [3:0]  m_dp;
    int          m_age;
    logic [7:0]  m_segs;
    logic [3:0]  m_an;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_an;
        logic [7:0]  exp_segs;
    } vec_t;

    vec_t tbl1 [16];
    vec_t tbl2 [17];

    // Glyphs by segment letters, active-high, bit0=a .. bit6=g
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0111111; // a b c d e f
            4'h1: return 7'b0000110; // b c
            4'h2: return 7'b1011011; // a b d e g
            4'h3: return 7'b1001111; // a b c d g
            4'h4: return 7'b1100110; // b c f g
            4'h5: return 7'b1101101; // a c d f g
            4'h6: return 7'b1111101; // a c d e f g
            4'h7: return 7'b0000111; // a b c
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111; // a b c d f g
            4'hA: return 7'b1110111; // a b c e f g
            4'hB: return 7'b1111100; // c d e f g
            4'hC: return 7'b0111001; // a d e f
            4'hD: return 7'b1011110; // b c d e g
            4'hE: return 7'b1111001; // a d e f g
            default: return 7'b1110001; // F: a e f g
        endcase
    endfunction

    function automatic int m_digit();
        return (m_age / R) % 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance model, then compare registered outputs.
    task automatic step();
        logic [3:0] nan;
        logic [7:0] nsegs;
        int d;
        @(posedge clk);
        if (!RST_N) begin
            m_data = 16'h0; m_en = 1'b1; m_blank = 1'b1; m_dp = 4'h0; m_age = 0;
            nan = 4'hF; nsegs = 8'hFF;
        end else begin
            nan = 4'hF; nsegs = 8'hFF;
            if (m_en) begin
                d = m_digit();
                nan = ~(4'b0001 << d);
                nsegs[7] = ~m_dp[d];
                if (m_blank && d != 0 && (m_data >> (4 * d)) == 16'h0) nsegs[6:0] = 7'h7F;
                else nsegs[6:0] = ~glyph(m_data[4*d +: 4]);
            end
            m_age = m_en ? (m_age + 1) % (4 * R) : 0;
            if (IOBUS_WR && IOBUS_ADDR == A_DATA) m_data = IOBUS_OUT[15:0];
            if (IOBUS_WR && IOBUS_ADDR == A_CTRL) begin
                m_dp = IOBUS_OUT[7:4]; m_blank = IOBUS_OUT[1]; m_en = IOBUS_OUT[0];
            end
        end
        m_an = nan; m_segs = nsegs;
        #1;
        check("an_model", 32'(an), 32'(m_an));
        check("segs_model", 32'(segs), 32'(m_segs));
    endtask

    task automatic bus_check(input logic [31:0] addr);
        logic [31:0] exp_rd;
        logic exp_sel;
        IOBUS_ADDR = addr;
        #1;
        exp_sel = 1'b1;
        if (addr == A_DATA)        exp_rd = {16'h0, m_data};
        else if (addr == A_CTRL)   exp_rd = {24'h0, m_dp, 2'b00, m_blank, m_en};
        else if (addr == A_STATUS) exp_rd = 32'(m_digit());
        else begin exp_rd = 32'h0; exp_sel = 1'b0; end
        check("sel", 32'(SEL), 32'(exp_sel));
        check("rd_data", RD_DATA, exp_rd);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; IOBUS_WR = 1'b0;
        step();
        RST_N = 1'b1;
    endtask

    task automatic wr_cycle(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_WR = 1'b1; IOBUS_ADDR = addr; IOBUS_OUT = data;
        step();
        IOBUS_WR = 1'b0;
    endtask

    function automatic logic [7:0] digit_lookup(input logic [3:0] a, input logic [7:0] s0,
                                                input logic [7:0] s1, input logic [7:0] s2,
                                                input logic [7:0] s3);
        case (a)
            4'hE: return s0;
            4'hD: return s1;
            4'hB: return s2;
            4'h7: return s3;
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        logic [3:0]  an_seq [4];
        logic [7:0]  s2_seq [4];
        logic [31:0] wd;
        logic [31:0] addrs [4];
        int lit, found;

        an_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
        s2_seq = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        addrs  = '{A_DATA, A_CTRL, A_STATUS, A_OTHER};
        for (int i = 0; i < 16; i++)
            tbl1[i] = '{1'b0, A_OTHER, 32'h0, an_seq[i/4], (i < 4) ? 8'hC0 : 8'hFF};
        tbl2[0] = '{1'b1, A_DATA, 32'h0000_12AF, 4'hE, 8'hC0};
        for (int i = 1; i < 17; i++)
            tbl2[i] = '{1'b0, A_OTHER, 32'h0, an_seq[(i/4)%4], s2_seq[(i/4)%4]};

        RST_N = 1'b0; IOBUS_WR = 1'b0; IOBUS_ADDR = A_OTHER; IOBUS_OUT = 32'h0;
        m_data = 16'h0; m_en = 1'b1; m_blank = 1'b1; m_dp = 4'h0; m_age = 0;

        // Reset state
        do_reset();
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_segs", 32'(segs), 32'h000000FF);
        bus_check(A_CTRL);
        check("rst_ctrl", RD_DATA, 32'h0000_0003);

        // Idle scan after reset, leading zeros blanked
        for (int i = 0; i < 16; i++) begin
            IOBUS_WR = tbl1[i].wr; IOBUS_ADDR = tbl1[i].addr; IOBUS_OUT = tbl1[i].wdata;
            step();
            check($sformatf("t1_an[%0d]", i), 32'(an), 32'(tbl1[i].exp_an));
            check($sformatf("t1_segs[%0d]", i), 32'(segs), 32'(tbl1[i].exp_segs));
        end
        IOBUS_WR = 1'b0;

        // Data write, visible on the next cycle
        do_reset();
        for (int i = 0; i < 17; i++) begin
            IOBUS_WR = tbl2[i].wr; IOBUS_ADDR = tbl2[i].addr; IOBUS_OUT = tbl2[i].wdata;
            step();
            check($sformatf("t2_an[%0d]", i), 32'(an), 32'(tbl2[i].exp_an));
            check($sformatf("t2_segs[%0d]", i), 32'(segs), 32'(tbl2[i].exp_segs));
        end
        IOBUS_WR = 1'b0;

        // No blanking, decimal point on digit 1
        wr_cycle(A_DATA, 32'h0000_0050);
        wr_cycle(A_CTRL, 32'h0000_0021);
        for (int i = 0; i < 16; i++) begin
            step();
            check("t3_segs", 32'(segs), 32'(digit_lookup(an, 8'hC0, 8'h12, 8'hC0, 8'hC0)));
        end

        // Disable mid-scan, then re-enable
        step(); step();
        wr_cycle(A_CTRL, 32'h0000_0000);
        step();
        check("t4_dark_an", 32'(an), 32'h0000000F);
        check("t4_dark_segs", 32'(segs), 32'h000000FF);
        bus_check(A_STATUS);
        check("t4_status", RD_DATA, 32'h0);
        step(); step();
        wr_cycle(A_CTRL, 32'h0000_0003);
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (an == 4'hE) lit++;
        end
        check("t4_dig0_len", 32'(lit), 32'(R));

        // Register reads and a write to the read-only status register
        bus_check(A_DATA);
        check("t5_data", RD_DATA, 32'h0000_0050);
        bus_check(A_CTRL);
        check("t5_ctrl", RD_DATA, 32'h0000_0003);
        bus_check(A_STATUS);
        bus_check(A_OTHER);
        wr_cycle(A_STATUS, 32'hFFFF_FFFF);
        bus_check(A_DATA);
        check("t5_data_kept", RD_DATA, 32'h0000_0050);
        bus_check(A_CTRL);
        check("t5_ctrl_kept", RD_DATA, 32'h0000_0003);

        // Reset coinciding with a data write while digit 2 is shown
        found = 0;
        IOBUS_ADDR = A_STATUS;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            bus_check(A_STATUS);
            if (RD_DATA == 32'd2) found = 1;
        end
        check("t6_reach_d2", 32'(found), 32'd1);
        RST_N = 1'b0; IOBUS_WR = 1'b1; IOBUS_ADDR = A_DATA; IOBUS_OUT = 32'h0000_1234;
        step();
        RST_N = 1'b1; IOBUS_WR = 1'b0;
        check("t6_dark_an", 32'(an), 32'h0000000F);
        check("t6_dark_segs", 32'(segs), 32'h000000FF);
        bus_check(A_DATA);
        check("t6_data_zero", RD_DATA, 32'h0);
        lit = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (an == 4'hE) lit++;
        end
        check("t6_dig0_len", 32'(lit), 32'(R));

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus_check(addrs[$urandom_range(0, 3)]);
            RST_N = ($urandom_range(0, 29) != 0);
            IOBUS_WR = ($urandom_range(0, 2) == 0);
            IOBUS_ADDR = addrs[$urandom_range(0, 3)];
            wd = $urandom;
            if (IOBUS_ADDR == A_DATA) wd = wd & {$urandom_range(0, 1) ? 16'hFFFF : 16'h0, 4'($urandom), 12'hFFF};
            if (IOBUS_ADDR == A_CTRL && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            IOBUS_OUT = wd;
            step();
        end
        RST_N = 1'b1; IOBUS_WR = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
